// File: rtl/instruction_refill_unit_pkg.sv
// Shared line-layout definitions for the L1 instruction cache and its refill unit.
package instruction_refill_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    FILL    = 2'd2,
    RESPOND = 2'd3
  } refill_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int block_width(input int words, input int data_width);
    return words * data_width;
  endfunction

  function automatic int word_select(input int words);
    return clog2(words);
  endfunction

endpackage

// File: rtl/instruction_refill_unit.sv
// Single-outstanding instruction line refill: one burst request, WORD_PER_BLOCK beats
// assembled MSB-first into a line, then handed back to L1 over valid/ready.
module instruction_refill_unit
  import instruction_refill_unit_pkg::*;
#(
  parameter  int ADDRESS_WIDTH  = 32,
  parameter  int DATA_WIDTH     = 32,
  parameter  int WORD_PER_BLOCK = 16,
  localparam int BLOCK_WIDTH    = block_width(WORD_PER_BLOCK, DATA_WIDTH),
  localparam int WORD_SELECT    = word_select(WORD_PER_BLOCK)
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     ADDRESS_TO_L2_VALID_INS,
  output logic                     ADDRESS_TO_L2_READY_INS,
  input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
  output logic                     DATA_FROM_L2_VALID_INS,
  input  logic                     DATA_FROM_L2_READY_INS,
  output logic [BLOCK_WIDTH-1:0]   DATA_FROM_L2_INS,
  output logic                     MEM_REQ_VALID,
  input  logic                     MEM_REQ_READY,
  output logic [ADDRESS_WIDTH-3:0] MEM_REQ_ADDRESS,
  input  logic                     MEM_DATA_VALID,
  input  logic [DATA_WIDTH-1:0]    MEM_DATA,
  output logic                     REFILL_BUSY
);

  refill_state_e            state;
  logic [WORD_SELECT-1:0]   beat_cnt;
  logic [WORD_PER_BLOCK-1:0] slot_we;

  // Handshake outputs decode straight from the state register: no input-to-output path.
  assign ADDRESS_TO_L2_READY_INS = (state == IDLE);
  assign MEM_REQ_VALID           = (state == REQUEST);
  assign DATA_FROM_L2_VALID_INS  = (state == RESPOND);
  assign REFILL_BUSY             = (state != IDLE);

  always_comb begin
    slot_we = '0;
    if (state == FILL && MEM_DATA_VALID) slot_we[beat_cnt] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state            <= IDLE;
      beat_cnt         <= '0;
      MEM_REQ_ADDRESS  <= '0;
      DATA_FROM_L2_INS <= '0;
    end else begin
      case (state)
        IDLE: if (ADDRESS_TO_L2_VALID_INS) begin
          MEM_REQ_ADDRESS  <= {ADDRESS_TO_L2_INS[ADDRESS_WIDTH-3:WORD_SELECT], {WORD_SELECT{1'b0}}};
          beat_cnt         <= '0;
          DATA_FROM_L2_INS <= '0;
          state            <= REQUEST;
        end
        REQUEST: if (MEM_REQ_READY) state <= FILL;
        FILL: if (MEM_DATA_VALID) begin
          // Counter wraps to 0 on the last beat; it is re-cleared on the next accept anyway.
          beat_cnt <= beat_cnt + WORD_SELECT'(1);
          if (beat_cnt == WORD_SELECT'(WORD_PER_BLOCK - 1)) state <= RESPOND;
        end
        RESPOND: if (DATA_FROM_L2_READY_INS) state <= IDLE;
        default: state <= IDLE;
      endcase
      // Word k lands in the k-th slot from the top so word 0 sits in the MSBs.
      for (int k = 0; k < WORD_PER_BLOCK; k++)
        if (slot_we[k]) DATA_FROM_L2_INS[BLOCK_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH] <= MEM_DATA;
    end
  end

endmodule

// File: tb/tb_instruction_refill_unit.sv
// Bench for instruction_refill_unit: table vectors, corner sequences and random refills.
module tb_instruction_refill_unit;
  localparam int AW = 32, DW = 32, WPB = 16, BW = WPB * DW;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          addr_valid = 1'b0, addr_ready;
  logic [AW-3:0] addr = '0;
  logic          line_valid, line_ready = 1'b0;
  logic [BW-1:0] line;
  logic          req_valid, req_ready = 1'b0;
  logic [AW-3:0] req_addr;
  logic          mem_valid = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic          busy;

  always #5 CLK = ~CLK;

  instruction_refill_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WORD_PER_BLOCK(WPB)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .ADDRESS_TO_L2_VALID_INS(addr_valid), .ADDRESS_TO_L2_READY_INS(addr_ready),
    .ADDRESS_TO_L2_INS(addr),
    .DATA_FROM_L2_VALID_INS(line_valid), .DATA_FROM_L2_READY_INS(line_ready),
    .DATA_FROM_L2_INS(line),
    .MEM_REQ_VALID(req_valid), .MEM_REQ_READY(req_ready), .MEM_REQ_ADDRESS(req_addr),
    .MEM_DATA_VALID(mem_valid), .MEM_DATA(mem_data), .REFILL_BUSY(busy)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] beats [WPB];

  typedef struct {
    logic [AW-3:0] a;
    int            req_stall;
    int            gap_mode;   // 0 none, 1 every other cycle, 2 random
    int            resp_stall;
    logic [DW-1:0] base;
    logic [AW-3:0] exp_req;
    logic [DW-1:0] exp_msb;
    logic [DW-1:0] exp_lsb;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Reference line: beats stacked in arrival order, first beat ending up on top.
  function automatic logic [BW-1:0] model_line();
    logic [BW-1:0] l;
    l = '0;
    for (int k = 0; k < WPB; k++) l = {l[BW-DW-1:0], beats[k]};
    return l;
  endfunction

  function automatic logic [AW-3:0] align(input logic [AW-3:0] a);
    return (a / WPB) * WPB;
  endfunction

  task automatic refill(input logic [AW-3:0] a, input int req_stall, input int gap_mode,
                        input int resp_stall, input bit offer_next, input logic [AW-3:0] nxt,
                        input string tag, output logic [AW-3:0] obs_req, output logic [BW-1:0] obs_line);
    int gaps;
    logic [BW-1:0] exp_line;
    gaps = 0;
    exp_line = model_line();
    check({tag, ".addr_ready_idle"}, addr_ready, 1);
    addr_valid = 1; addr = a; cyc = 0;
    step();
    addr_valid = 0; addr = AW'($urandom);
    check({tag, ".req_valid_c1"}, req_valid, 1);
    check({tag, ".busy"}, busy, 1);
    check({tag, ".addr_ready_req"}, addr_ready, 0);
    obs_req = req_addr;
    for (int i = 0; i < req_stall; i++) begin
      step();
      check({tag, ".req_hold_valid"}, req_valid, 1);
      check({tag, ".req_hold_addr"}, req_addr, align(a));
    end
    req_ready = 1;
    step();
    req_ready = 0;
    for (int k = 0; k < WPB; k++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        mem_valid = 0;
        step();
        gaps++;
      end
      mem_valid = 1; mem_data = beats[k];
      step();
    end
    mem_valid = 0;
    check({tag, ".line_valid"}, line_valid, 1);
    check({tag, ".line_latency"}, cyc, 18 + req_stall + gaps);
    check({tag, ".line"}, line, exp_line);
    obs_line = line;
    for (int i = 0; i < resp_stall; i++) begin
      addr_valid = offer_next; addr = nxt;
      mem_valid = 1; mem_data = 32'hDEADBEEF;
      step();
      check({tag, ".no_accept_resp"}, addr_ready, 0);
      check({tag, ".line_hold_valid"}, line_valid, 1);
      check({tag, ".line_hold"}, line, exp_line);
    end
    mem_valid = 0;
    if (offer_next) begin addr_valid = 1; addr = nxt; end
    line_ready = 1;
    step();
    line_ready = 0;
    check({tag, ".line_valid_drop"}, line_valid, 0);
    check({tag, ".addr_ready_back"}, addr_ready, 1);
    check({tag, ".idle_not_busy"}, busy, 0);
    check({tag, ".buffer_kept"}, line, exp_line);
  endtask

  logic [AW-3:0] o_req;
  logic [BW-1:0] o_line;

  initial begin
    tbl[0] = '{30'h0000_1234, 0, 0, 0, 32'h0000_1000, 30'h0000_1230, 32'h0000_1000, 32'h0000_100F};
    tbl[1] = '{30'h3FFF_FFFF, 5, 1, 3, 32'hFFFF_FFF8, 30'h3FFF_FFF0, 32'hFFFF_FFF8, 32'h0000_0007};
    tbl[2] = '{30'h0000_0000, 1, 0, 1, 32'h0000_0000, 30'h0000_0000, 32'h0000_0000, 32'h0000_000F};
    tbl[3] = '{30'h2000_0007, 2, 2, 0, 32'h5A5A_0000, 30'h2000_0000, 32'h5A5A_0000, 32'h5A5A_000F};

    // Reset state
    #12;
    check("rst.addr_ready", addr_ready, 1);
    check("rst.req_valid", req_valid, 0);
    check("rst.req_addr", req_addr, 0);
    check("rst.line_valid", line_valid, 0);
    check("rst.line", line, 0);
    check("rst.busy", busy, 0);
    @(negedge CLK);
    RSTN = 1;
    step();

    // Stray beat while idle
    mem_valid = 1; mem_data = 32'hDEADBEEF;
    step();
    mem_valid = 0;
    check("stray_idle.line", line, 0);
    check("stray_idle.valid", line_valid, 0);
    check("stray_idle.busy", busy, 0);

    // Table-driven refills
    foreach (tbl[i]) begin
      for (int k = 0; k < WPB; k++) beats[k] = tbl[i].base + DW'(k);
      refill(tbl[i].a, tbl[i].req_stall, tbl[i].gap_mode, tbl[i].resp_stall, 1'b0, '0,
             $sformatf("tbl%0d", i), o_req, o_line);
      check($sformatf("tbl%0d.req_addr", i), o_req, tbl[i].exp_req);
      check($sformatf("tbl%0d.msb_word", i), o_line[BW-1 -: DW], tbl[i].exp_msb);
      check($sformatf("tbl%0d.lsb_word", i), o_line[DW-1:0], tbl[i].exp_lsb);
      mem_valid = 1; mem_data = 32'hDEADBEEF;
      step();
      mem_valid = 0;
      check($sformatf("tbl%0d.stray_after", i), line, o_line);
      check($sformatf("tbl%0d.stray_no_valid", i), line_valid, 0);
    end

    // Reset in the middle of FILL
    for (int k = 0; k < WPB; k++) beats[k] = 32'hA000_0000 + DW'(k);
    addr_valid = 1; addr = 30'h00AB_CDE5;
    step();
    addr_valid = 0; req_ready = 1;
    step();
    req_ready = 0;
    for (int k = 0; k < 8; k++) begin
      mem_valid = 1; mem_data = beats[k];
      step();
    end
    mem_valid = 0;
    RSTN = 0;
    #1;
    check("midrst.addr_ready", addr_ready, 1);
    check("midrst.busy", busy, 0);
    check("midrst.req_valid", req_valid, 0);
    check("midrst.line", line, 0);
    @(negedge CLK);
    RSTN = 1;
    step();
    for (int k = 0; k < WPB; k++) beats[k] = 32'hB000_0000 + DW'(k * 3);
    refill(30'h0000_4444, 0, 0, 0, 1'b0, '0, "postrst", o_req, o_line);
    check("postrst.req_addr", o_req, 30'h0000_4440);

    // Back-to-back: second address offered throughout RESPOND
    for (int k = 0; k < WPB; k++) beats[k] = 32'hC000_0000 | DW'(k << 8);
    refill(30'h0000_0100, 0, 0, 3, 1'b1, 30'h0000_0215, "b2b_first", o_req, o_line);
    for (int k = 0; k < WPB; k++) beats[k] = 32'hD000_0000 - DW'(k);
    refill(30'h0000_0215, 0, 0, 0, 1'b0, '0, "b2b_second", o_req, o_line);
    check("b2b_second.req_addr", o_req, 30'h0000_0210);
    check("b2b_second.lsb", o_line[DW-1:0], 32'hCFFF_FFF1);

    // Random refills against the reference model
    for (int r = 0; r < 15; r++) begin
      logic [AW-3:0] ra;
      ra = AW'($urandom);
      for (int k = 0; k < WPB; k++) beats[k] = $urandom;
      refill(ra, $urandom_range(0, 3), 2, $urandom_range(0, 2), 1'b0, '0,
             $sformatf("rnd%0d", r), o_req, o_line);
      check($sformatf("rnd%0d.req_addr", r), o_req, align(ra));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_refill_unit.md
# instruction_refill_unit

Sits between the L1 instruction cache miss path and the word-wide backing memory bus. It accepts one block-refill word address from the L1 instruction cache and issues a single burst request to memory. It assembles WORD_PER_BLOCK returned words into one cache line and hands the complete line back to L1 over a valid/ready channel. Only one refill is outstanding at a time.

## Interface
- ADDRESS_WIDTH, 32, byte address width of the core.
- DATA_WIDTH, 32, width of one memory beat / instruction word.
- WORD_PER_BLOCK, 16, words per cache line (power of two).
- BLOCK_WIDTH (local), WORD_PER_BLOCK*DATA_WIDTH, refill line width.
- WORD_SELECT (local), clog2 of WORD_PER_BLOCK, word-index bits inside a line.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- ADDRESS_TO_L2_VALID_INS  in  1  L1 presents a refill address.
- ADDRESS_TO_L2_READY_INS  out  1  unit can accept an address.
- ADDRESS_TO_L2_INS  in  ADDRESS_WIDTH-2  word address of the missing instruction.
- DATA_FROM_L2_VALID_INS  out  1  assembled line valid.
- DATA_FROM_L2_READY_INS  in  1  L1 accepts the line.
- DATA_FROM_L2_INS  out  BLOCK_WIDTH  assembled line.
- MEM_REQ_VALID  out  1  burst request valid.
- MEM_REQ_READY  in  1  memory accepts the request.
- MEM_REQ_ADDRESS  out  ADDRESS_WIDTH-2  line-aligned word address.
- MEM_DATA_VALID  in  1  one returned word this cycle; no backpressure.
- MEM_DATA  in  DATA_WIDTH  returned word.
- REFILL_BUSY  out  1  high in any state other than IDLE.

## Operation
- FSM with four states: IDLE, REQUEST, FILL, RESPOND.
- IDLE:
  - ADDRESS_TO_L2_READY_INS = 1.
  - On VALID & READY: latch the address with its low WORD_SELECT bits forced to 0, clear the beat counter and the line buffer, then go to REQUEST.
- REQUEST:
  - MEM_REQ_VALID = 1 and MEM_REQ_ADDRESS = the latched aligned address, both held stable until MEM_REQ_READY.
  - On MEM_REQ_READY go to FILL.
- FILL:
  - Each MEM_DATA_VALID writes MEM_DATA into word slot k = beat counter, then the counter increments.
  - Slot k occupies bits [BLOCK_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH], so word 0 sits in the MSBs, matching the L1 word mux ordering.
  - The beat with counter = WORD_PER_BLOCK-1 moves the FSM to RESPOND. The counter wraps to 0 and is not used again until re-cleared.
- RESPOND:
  - DATA_FROM_L2_VALID_INS = 1 and DATA_FROM_L2_INS = the line buffer, both held stable until DATA_FROM_L2_READY_INS.
  - On ready go to IDLE.
- MEM_DATA_VALID outside FILL is ignored; buffer and counter are unchanged.
- ADDRESS_TO_L2_READY_INS is 0 in REQUEST, FILL and RESPOND. A new address is never accepted in the same cycle as line delivery.

## Timing
- All outputs are driven from registers or decoded directly from the state register; there is no combinational path from any input to any output.
- Reset values: state IDLE, ADDRESS_TO_L2_READY_INS 1, MEM_REQ_VALID 0, MEM_REQ_ADDRESS 0, DATA_FROM_L2_VALID_INS 0, DATA_FROM_L2_INS 0, REFILL_BUSY 0, beat counter 0.
- Minimum latency, counting the address handshake as cycle 0 and assuming MEM_REQ_READY high and MEM_DATA_VALID every cycle:
  - MEM_REQ_VALID in cycle 1.
  - Beats in cycles 2 to 17.
  - DATA_FROM_L2_VALID_INS from cycle 18.
  - With immediate ready, ADDRESS_TO_L2_READY_INS is high again in cycle 19.
- Gaps in MEM_DATA_VALID stretch FILL with no loss of data.
- Reset asserted mid-refill returns the unit to IDLE immediately (asynchronous) and discards the partial line. The memory side is responsible for dropping any in-flight burst.

## Structure
- Shared package holds:
  - State encoding constants (IDLE=2'd0, REQUEST=2'd1, FILL=2'd2, RESPOND=2'd3).
  - The clog2 function.
  - The BLOCK_WIDTH / WORD_SELECT derivations, so the L1 cache and this unit agree on line layout.
- Single module; no sub-module needed. The line buffer is a BLOCK_WIDTH register with per-slot write enables decoded from the beat counter.

## Test plan
- Reset then idle: RSTN low then high → READY=1, MEM_REQ_VALID=0, DATA_FROM_L2_VALID_INS=0, DATA_FROM_L2_INS=0.
- Basic refill: address 0x0000_1234 accepted, MEM_REQ_READY held 1, beats 0x1000+k for k=0..15 → MEM_REQ_ADDRESS=0x0000_1230 in cycle 1, line MSB word=0x1000 and LSB word=0x100F, valid in cycle 18.
- Backpressure: MEM_REQ_READY low for 5 cycles, MEM_DATA_VALID gapped every other cycle, DATA_FROM_L2_READY_INS low for 3 cycles → request and line held stable, line contents correct, no address accepted until delivery.
- Stray beats: MEM_DATA_VALID pulsed in IDLE and RESPOND with data 0xDEADBEEF → buffer unchanged, no extra valid.
- Reset mid-FILL: RSTN pulsed low after beat 7 → IDLE next edge, then a full new refill returns only new data with no residue in any slot.
- Back-to-back refills: second VALID asserted during RESPOND → not accepted until the cycle after DATA_FROM_L2_READY_INS; second line correct.
